// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS32 main controller: opcodes,
// ALUOp codes (shared with the ALU control decoder), mux select codes,
// state encoding and the bundled control-signal struct.
package ctrl_pkg;

    // Opcodes handled by the controller
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALUOp codes consumed by the ALU control decoder
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_FUNC = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    // Write-register select
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // Write-data select
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    // State encoding
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_R_WB     = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_I_WB     = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WB   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    typedef struct packed {
        logic       pc_write;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_sig_t;

    // ALU operation for the immediate-ALU group
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_XORI:  return ALU_XOR;
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            default:  return ALU_ADD;
        endcase
    endfunction

    // True for every opcode the controller can sequence
    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational output map of the main controller: state plus latched opcode
// give the Moore outputs; mem_ready, zero and jr gate the few Mealy terms.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic       jr,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_sig_t  sig
);

    // Per-state control decode; anything not driven stays 0
    always_comb begin
        sig = '0;
        case (state)
            S_FETCH: begin
                sig.mem_read  = 1'b1;
                sig.ior_d     = 1'b0;
                sig.alu_src_a = 1'b0;
                sig.alu_src_b = SRCB_FOUR;
                sig.alu_op    = ALU_ADD;
                sig.pc_source = PCSRC_ALU;
                sig.ir_write  = mem_ready;
                sig.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut
                sig.alu_src_a = 1'b0;
                sig.alu_src_b = SRCB_IMMSH;
                sig.alu_op    = ALU_ADD;
                sig.illegal   = ~op_legal(op);
            end
            S_EXEC_R: begin
                sig.alu_src_a = 1'b1;
                sig.alu_src_b = SRCB_REG;
                sig.alu_op    = ALU_FUNC;
                if (jr) begin
                    sig.pc_source = PCSRC_REG;
                    sig.pc_write  = 1'b1;
                end
            end
            S_R_WB: begin
                sig.reg_write  = 1'b1;
                sig.reg_dst    = REGDST_RD;
                sig.mem_to_reg = M2R_ALUOUT;
            end
            S_EXEC_I: begin
                sig.alu_src_a = 1'b1;
                sig.alu_src_b = SRCB_IMM;
                sig.alu_op    = imm_alu_op(op);
            end
            S_I_WB: begin
                sig.reg_write  = 1'b1;
                sig.reg_dst    = REGDST_RT;
                sig.mem_to_reg = M2R_ALUOUT;
            end
            S_MEM_ADDR: begin
                sig.alu_src_a = 1'b1;
                sig.alu_src_b = SRCB_IMM;
                sig.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                sig.mem_read = 1'b1;
                sig.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                sig.reg_write  = 1'b1;
                sig.reg_dst    = REGDST_RT;
                sig.mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                sig.mem_write = 1'b1;
                sig.ior_d     = 1'b1;
            end
            S_BRANCH: begin
                sig.alu_src_a = 1'b1;
                sig.alu_src_b = SRCB_REG;
                sig.alu_op    = ALU_SUB;
                sig.pc_source = PCSRC_ALUOUT;
                sig.pc_write  = (op == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                sig.pc_source = PCSRC_JUMP;
                sig.pc_write  = 1'b1;
                // jal links PC+4, which the register file captures before the edge
                if (op == OP_JAL) begin
                    sig.reg_write  = 1'b1;
                    sig.reg_dst    = REGDST_RA;
                    sig.mem_to_reg = M2R_PC;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle MIPS32 main controller: holds the state and opcode registers
// and the next-state logic; output decode lives in ctrl_out_decode.
module main_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] instr_op,
    input  logic       jr,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ior_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [5:0] op_q;
    ctrl_sig_t  sig;

    // State and opcode registers; opcode captured when the fetch completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            op_q  <= 6'd0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && mem_ready)
                op_q <= instr_op;
        end
    end

    // Next-state selection
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_q)
                    OP_RTYPE:                     state_nxt = S_EXEC_R;
                    OP_LW, OP_SW:                 state_nxt = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:               state_nxt = S_BRANCH;
                    OP_J, OP_JAL:                 state_nxt = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI:     state_nxt = S_EXEC_I;
                    default:                      state_nxt = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_nxt = jr ? S_FETCH : S_R_WB;
            S_R_WB:     state_nxt = S_FETCH;
            S_EXEC_I:   state_nxt = S_I_WB;
            S_I_WB:     state_nxt = S_FETCH;
            S_MEM_ADDR: state_nxt = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_nxt = S_FETCH;
            S_MEM_WR:   state_nxt = mem_ready ? S_FETCH : S_MEM_WR;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JUMP:     state_nxt = S_FETCH;
            default:    state_nxt = S_FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .state     (state),
        .op        (op_q),
        .jr        (jr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .sig       (sig)
    );

    // Write enables are held off combinationally for as long as reset is high
    assign pc_write   = sig.pc_write  & ~reset;
    assign ir_write   = sig.ir_write  & ~reset;
    assign reg_write  = sig.reg_write & ~reset;
    assign mem_write  = sig.mem_write & ~reset;
    assign ior_d      = sig.ior_d;
    assign mem_read   = sig.mem_read;
    assign reg_dst    = sig.reg_dst;
    assign mem_to_reg = sig.mem_to_reg;
    assign alu_src_a  = sig.alu_src_a;
    assign alu_src_b  = sig.alu_src_b;
    assign pc_source  = sig.pc_source;
    assign alu_op     = sig.alu_op;
    assign illegal    = sig.illegal;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm: inputs change 1 time unit after each
// rising edge, outputs and state are compared 2 units later, mid-cycle.
module tb_main_ctrl_fsm;
    import ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] instr_op;
    logic       jr;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    main_ctrl_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .instr_op   (instr_op),
        .jr         (jr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ior_d      (ior_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .alu_op     (alu_op),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge
    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs and the state register against hand-computed values
    task automatic cyc_chk(input string tag, input logic [3:0] st,
                           input logic pw, input logic iord, input logic mr,
                           input logic mw, input logic irw, input logic rw,
                           input logic [1:0] rdst, input logic [1:0] m2r,
                           input logic asa, input logic [1:0] asb,
                           input logic [1:0] pcs, input logic [2:0] aop,
                           input logic ill);
        logic [18:0] obs;
        logic [18:0] exp;
        exp = {pw, iord, mr, mw, irw, rw, rdst, m2r, asa, asb, pcs, aop, ill};
        obs = {pc_write, ior_d, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op, illegal};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s outputs observed=%05h expected=%05h", tag, obs, exp);
        end
        checks++;
        assert (dut.state === st) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, dut.state, st);
        end
    endtask

    // FETCH with zero wait states, then DECODE of a legal opcode
    task automatic run_fetch(input string tag, input logic [5:0] op);
        nc(); instr_op = op; mem_ready = 1'b1; #2;
        cyc_chk({tag, "_fetch"}, S_FETCH, 1,0,1,0,1,0, 2'd0,2'd0, 0,2'd1,2'd0,3'd0, 0);
        nc(); instr_op = 6'h3F; #2;
        cyc_chk({tag, "_dec"}, S_DECODE, 0,0,0,0,0,0, 2'd0,2'd0, 0,2'd3,2'd0,3'd0, 0);
    endtask

    task automatic do_branch(input string tag, input logic [5:0] op,
                             input logic z, input logic pw);
        run_fetch(tag, op);
        nc(); zero = z; #2;
        cyc_chk({tag, "_br"}, S_BRANCH, pw,0,0,0,0,0, 2'd0,2'd0, 1,2'd0,2'd1,3'd1, 0);
        zero = 1'b0;
    endtask

    initial begin
        reset = 1'b1; instr_op = 6'h00; jr = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        // In reset: FETCH decode with pc_write/ir_write forced low despite mem_ready
        cyc_chk("rst", S_FETCH, 0,0,1,0,0,0, 2'd0,2'd0, 0,2'd1,2'd0,3'd0, 0);

        // addi: FETCH, DECODE, EXEC_I, I_WB
        nc(); reset = 1'b0; instr_op = 6'h08; mem_ready = 1'b1; #2;
        cyc_chk("addi_fetch", S_FETCH, 1,0,1,0,1,0, 2'd0,2'd0, 0,2'd1,2'd0,3'd0, 0);
        nc(); instr_op = 6'h3F; #2;
        cyc_chk("addi_dec", S_DECODE, 0,0,0,0,0,0, 2'd0,2'd0, 0,2'd3,2'd0,3'd0, 0);
        nc(); #2;
        cyc_chk("addi_exec", S_EXEC_I, 0,0,0,0,0,0, 2'd0,2'd0, 1,2'd2,2'd0,3'd0, 0);
        nc(); #2;
        cyc_chk("addi_wb", S_I_WB, 0,0,0,0,0,1, 2'd0,2'd0, 0,2'd0,2'd0,3'd0, 0);

        // lw: one fetch wait, two read waits -> 8 cycles
        nc(); instr_op = 6'h23; mem_ready = 1'b0; #2;
        cyc_chk("lw_fwait", S_FETCH, 0,0,1,0,0,0, 2'd0,2'd0, 0,2'd1,2'd0,3'd0, 0);
        nc(); mem_ready = 1'b1; #2;
        cyc_chk("lw_fetch", S_FETCH, 1,0,1,0,1,0, 2'd0,2'd0, 0,2'd1,2'd0,3'd0, 0);
        nc(); instr_op = 6'h2B; #2;
        cyc_chk("lw_dec", S_DECODE, 0,0,0,0,0,0, 2'd0,2'd0, 0,2'd3,2'd0,3'd0, 0);
        nc(); #2;
        cyc_chk("lw_addr", S_MEM_ADDR, 0,0,0,0,0,0, 2'd0,2'd0, 1,2'd2,2'd0,3'd0, 0);
        nc(); mem_ready = 1'b0; #2;
        cyc_chk("lw_rwait1", S_MEM_RD, 0,1,1,0,0,0, 2'd0,2'd0, 0,2'd0,2'd0,3'd0, 0);
        nc(); #2;
        cyc_chk("lw_rwait2", S_MEM_RD, 0,1,1,0,0,0, 2'd0,2'd0, 0,2'd0,2'd0,3'd0, 0);
        nc(); mem_ready = 1'b1; #2;
        cyc_chk("lw_rd", S_MEM_RD, 0,1,1,0,0,0, 2'd0,2'd0, 0,2'd0,2'd0,3'd0, 0);
        nc(); #2;
        cyc_chk("lw_wb", S_MEM_WB, 0,0,0,0,0,1, 2'd0,2'd1, 0,2'd0,2'd0,3'd0, 0);

        // beq / bne taken and not taken
        do_branch("beq_z1", 6'h04, 1'b1, 1'b1);
        do_branch("beq_z0", 6'h04, 1'b0, 1'b0);
        do_branch("bne_z0", 6'h05, 1'b0, 1'b1);
        do_branch("bne_z1", 6'h05, 1'b1, 1'b0);

        // jr finishes in EXEC_R
        run_fetch("jr", 6'h00);
        nc(); jr = 1'b1; #2;
        cyc_chk("jr_exec", S_EXEC_R, 1,0,0,0,0,0, 2'd0,2'd0, 1,2'd0,2'd3,3'd6, 0);

        // Plain R-type writes rd
        run_fetch("rtype", 6'h00);
        nc(); jr = 1'b0; #2;
        cyc_chk("rtype_exec", S_EXEC_R, 0,0,0,0,0,0, 2'd0,2'd0, 1,2'd0,2'd0,3'd6, 0);
        nc(); #2;
        cyc_chk("rtype_wb", S_R_WB, 0,0,0,0,0,1, 2'd1,2'd0, 0,2'd0,2'd0,3'd0, 0);

        // jal links into $31, j does not
        run_fetch("jal", 6'h03);
        nc(); #2;
        cyc_chk("jal_jump", S_JUMP, 1,0,0,0,0,1, 2'd2,2'd2, 0,2'd0,2'd2,3'd0, 0);
        run_fetch("j", 6'h02);
        nc(); #2;
        cyc_chk("j_jump", S_JUMP, 1,0,0,0,0,0, 2'd0,2'd0, 0,2'd0,2'd2,3'd0, 0);

        // Immediate ALU codes for sltiu and ori
        run_fetch("sltiu", 6'h0B);
        nc(); #2;
        cyc_chk("sltiu_exec", S_EXEC_I, 0,0,0,0,0,0, 2'd0,2'd0, 1,2'd2,2'd0,3'd7, 0);
        nc(); #2;
        cyc_chk("sltiu_wb", S_I_WB, 0,0,0,0,0,1, 2'd0,2'd0, 0,2'd0,2'd0,3'd0, 0);
        run_fetch("ori", 6'h0D);
        nc(); #2;
        cyc_chk("ori_exec", S_EXEC_I, 0,0,0,0,0,0, 2'd0,2'd0, 1,2'd2,2'd0,3'd3, 0);
        nc(); #2;
        cyc_chk("ori_wb", S_I_WB, 0,0,0,0,0,1, 2'd0,2'd0, 0,2'd0,2'd0,3'd0, 0);

        // Illegal opcode: one-cycle pulse in DECODE, then FETCH
        nc(); instr_op = 6'h3F; mem_ready = 1'b1; #2;
        cyc_chk("ill_fetch", S_FETCH, 1,0,1,0,1,0, 2'd0,2'd0, 0,2'd1,2'd0,3'd0, 0);
        nc(); instr_op = 6'h00; #2;
        cyc_chk("ill_dec", S_DECODE, 0,0,0,0,0,0, 2'd0,2'd0, 0,2'd3,2'd0,3'd0, 1);

        // sw interrupted by reset while waiting in MEM_WR
        run_fetch("sw", 6'h2B);
        nc(); #2;
        cyc_chk("sw_addr", S_MEM_ADDR, 0,0,0,0,0,0, 2'd0,2'd0, 1,2'd2,2'd0,3'd0, 0);
        nc(); mem_ready = 1'b0; #2;
        cyc_chk("sw_wait1", S_MEM_WR, 0,1,0,1,0,0, 2'd0,2'd0, 0,2'd0,2'd0,3'd0, 0);
        nc(); #2;
        cyc_chk("sw_wait2", S_MEM_WR, 0,1,0,1,0,0, 2'd0,2'd0, 0,2'd0,2'd0,3'd0, 0);
        nc(); reset = 1'b1; mem_ready = 1'b1; #2;
        cyc_chk("sw_rst", S_FETCH, 0,0,1,0,0,0, 2'd0,2'd0, 0,2'd1,2'd0,3'd0, 0);
        nc(); reset = 1'b0; #2;
        cyc_chk("sw_after_rst", S_FETCH, 1,0,1,0,1,0, 2'd0,2'd0, 0,2'd1,2'd0,3'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
